sbox_word_seq: RTL and testbench
================================

SBOX_WORD_SEQ -- requirements
Module: sbox_word_seq

Interface
REQ-001 SHALL have parameter INV_LAT, default 0, legal range 0..3: cycles between a change on inv_byte_o and a valid inv_byte_i.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_i  input  1  request to invert one 32-bit word.
REQ-005 SHALL have port clear_i  input  1  synchronous abort of the word in flight.
REQ-006 SHALL have port word_i  input  32  word to invert bytewise; captured when start is accepted.
REQ-007 SHALL have port busy_o  output  1  high while a word is in flight or being delivered.
REQ-008 SHALL have port done_o  output  1  one-cycle pulse marking word_o valid.
REQ-009 SHALL have port word_o  output  32  bytewise GF(2^8) inverses of the captured word.
REQ-010 SHALL have port inv_byte_o  output  8  byte driven to the shared external inverter.
REQ-011 SHALL have port inv_byte_i  input  8  inverse returned by the shared external inverter.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; only IDLE accepts start_i.
REQ-013 SHALL accept start when state is IDLE, start_i=1 and clear_i=0 at a rising edge: capture word_i, byte index=0, wait count=0, go to RUN.
REQ-014 SHALL ignore start_i in RUN and DONE; word_i changes after acceptance SHALL not affect the result.
REQ-015 SHALL process bytes in order 0..3, byte k = captured word bits [8k+7:8k].
REQ-016 SHALL, in RUN, drive inv_byte_o = current byte k for exactly INV_LAT+1 consecutive cycles.
REQ-017 SHALL, on the rising edge ending the last of those INV_LAT+1 cycles, load inv_byte_i into result bits [8k+7:8k] and advance k (2-bit index, no wrap past 3).
REQ-018 SHALL, after byte 3 is loaded, go to DONE; RUN lasts exactly 4*(INV_LAT+1) cycles.
REQ-019 SHALL, in DONE, assert done_o=1 for exactly one cycle with word_o already holding the full result, then go to IDLE.
REQ-020 SHALL hold word_o stable from DONE until the next accepted start; result bytes SHALL not be visible on word_o during RUN (word_o updates only on entry to DONE).
REQ-021 SHALL drive busy_o=1 in RUN and DONE, 0 in IDLE.
REQ-022 SHALL drive inv_byte_o=8'h00 in IDLE and DONE.
REQ-023 Timing: start sampled at end of cycle 0 -> RUN cycles 1..4(INV_LAT+1), done_o in cycle 4(INV_LAT+1)+1, IDLE and accepting start in the following cycle; minimum spacing between accepted starts 4(INV_LAT+1)+2 cycles.
REQ-024 SHALL, when clear_i=1 in RUN or DONE, go to IDLE at the next edge, suppress done_o in the following cycle, and leave word_o at its prior value.
REQ-025 SHALL give clear_i priority over start_i when both are 1 in IDLE (no start accepted).
REQ-026 SHALL treat input 0x00 as mapping to whatever inv_byte_i returns (0x00 by convention); no special-casing in the sequencer.

Reset
REQ-027 SHALL, while reset_n=0, force state=IDLE, busy_o=0, done_o=0, word_o=32'h0, inv_byte_o=8'h00, byte index and wait count=0, independent of clk.
REQ-028 SHALL, on reset_n asserted mid-RUN, abandon the word with no done_o pulse after release.
REQ-029 SHALL accept a start on the first rising edge after reset_n deasserts.

Verification (bench wires a combinational PPRM or log inverter for INV_LAT=0; a registered-stage wrapper for INV_LAT=1..3)
REQ-030 INV_LAT=0, start with word_i=32'h03020100 -> inv_byte_o = 00,01,02,03 in cycles 1..4, done_o in cycle 5 only, word_o=32'hF68D0100, busy_o high cycles 1..5.
REQ-031 INV_LAT=2, start with word_i=32'h53535353 -> each byte held 3 cycles, RUN 12 cycles, done_o in cycle 13, word_o=32'hCACACACA.
REQ-032 Back-to-back: start held high continuously with INV_LAT=0 -> starts accepted every 6 cycles, each done_o single-cycle, word_i changes during RUN ignored.
REQ-033 clear_i=1 in RUN cycle 2 of word 32'h03020100 -> IDLE next cycle, no done_o, word_o keeps previous result, busy_o=0.
REQ-034 reset_n pulsed low mid-RUN, asynchronous to clk -> all outputs zero immediately, no done_o after release, fresh start then completes with the correct result.
REQ-035 Exhaustive: all 256 byte values placed in each byte lane across 256 words -> every word_o byte matches the precomputed inverse table.

Source files
------------

// File: rtl/sbox_word_seq.sv
// Bytewise GF(2^8) inversion of a 32-bit word through one shared external inverter.
// The word's bytes go to the inverter one after another, each held INV_LAT+1 cycles.
module sbox_word_seq #(
  parameter int INV_LAT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic        clear_i,
  input  logic [31:0] word_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] word_o,
  output logic [7:0]  inv_byte_o,
  input  logic [7:0]  inv_byte_i,
  output logic [1:0]  state_o
);

  // Handshake: start_i is taken only in IDLE with clear_i low; the word is
  // captured then, and done_o pulses once when word_o holds the full result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] LAST_WAIT = 2'(INV_LAT);

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] res_q, res_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  wait_q, wait_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  inv_q, inv_d;
  logic [1:0]  idx_nxt;

  assign idx_nxt = idx_q + 2'd1;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    res_d   = res_q;
    word_d  = word_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    inv_d   = inv_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        inv_d  = 8'h00;
        if (start_i && !clear_i) begin
          state_d = ST_RUN;
          src_d   = word_i;
          idx_d   = 2'd0;
          wait_d  = 2'd0;
          busy_d  = 1'b1;
          inv_d   = word_i[7:0];
        end
      end
      ST_RUN: begin
        if (clear_i) begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          wait_d  = 2'd0;
          busy_d  = 1'b0;
          inv_d   = 8'h00;
        end else if (wait_q == LAST_WAIT) begin
          // inv_byte_i has settled for the byte held since the last advance
          res_d[{idx_q, 3'b000} +: 8] = inv_byte_i;
          wait_d = 2'd0;
          if (idx_q == 2'd3) begin
            state_d = ST_DONE;
            word_d  = {inv_byte_i, res_q[23:0]};
            done_d  = 1'b1;
            inv_d   = 8'h00;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_nxt;
            inv_d = src_q[{idx_nxt, 3'b000} +: 8];
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        inv_d   = 8'h00;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        inv_d   = 8'h00;
        idx_d   = 2'd0;
        wait_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      res_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inv_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      res_q   <= res_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      inv_q   <= inv_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign word_o     = word_q;
  assign inv_byte_o = inv_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_sbox_word_seq.sv
// Bench for sbox_word_seq: one instance with a combinational inverter (INV_LAT=0)
// and one with a two-register inverter (INV_LAT=2), checked against a GF(2^8) table.
module tb_sbox_word_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic        start0 = 1'b0, clear0 = 1'b0;
  logic [31:0] word0 = '0;
  logic        busy0, done0;
  logic [31:0] wordo0;
  logic [7:0]  invo0, invi0;
  logic [1:0]  st0;

  logic        start2 = 1'b0, clear2 = 1'b0;
  logic [31:0] word2 = '0;
  logic        busy2, done2;
  logic [31:0] wordo2;
  logic [7:0]  invo2, invi2;
  logic [1:0]  st2;

  logic [7:0]  inv_tab [256];
  logic [7:0]  s1, s2;
  logic [31:0] last_res0 = '0;
  logic [31:0] last_res2 = '0;
  logic [31:0] exp_q [$];

  sbox_word_seq #(.INV_LAT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start_i(start0), .clear_i(clear0),
    .word_i(word0), .busy_o(busy0), .done_o(done0), .word_o(wordo0),
    .inv_byte_o(invo0), .inv_byte_i(invi0), .state_o(st0)
  );

  sbox_word_seq #(.INV_LAT(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start_i(start2), .clear_i(clear2),
    .word_i(word2), .busy_o(busy2), .done_o(done2), .word_o(wordo2),
    .inv_byte_o(invo2), .inv_byte_i(invi2), .state_o(st2)
  );

  assign invi0 = inv_tab[invo0];

  always @(posedge clk) begin
    s1 <= inv_tab[invo2];
    s2 <= s1;
  end
  assign invi2 = s2;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_word(input logic [31:0] w);
    return {inv_tab[w[31:24]], inv_tab[w[23:16]], inv_tab[w[15:8]], inv_tab[w[7:0]]};
  endfunction

  task automatic build_table();
    inv_tab[0] = 8'h00;
    for (int a = 1; a < 256; a++) begin
      for (int b = 1; b < 256; b++) begin
        if (gf_mul(8'(a), 8'(b)) == 8'h01) inv_tab[a] = 8'(b);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %0b exp 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done0 got %0b exp 0", done0); end
    checks++; if (wordo0 !== 32'h0) begin errors++; $display("FAIL reset_word0 got %h exp 0", wordo0); end
    checks++; if (invo0 !== 8'h00) begin errors++; $display("FAIL reset_inv0 got %h exp 0", invo0); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2 got %0b exp 0", busy2); end
    checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL reset_done2 got %0b exp 0", done2); end
    checks++; if (wordo2 !== 32'h0) begin errors++; $display("FAIL reset_word2 got %h exp 0", wordo2); end
    checks++; if (invo2 !== 8'h00) begin errors++; $display("FAIL reset_inv2 got %h exp 0", invo2); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_lat0_directed();
    logic [7:0]  e_inv;
    logic [31:0] e_word;
    @(negedge clk);
    start0 = 1'b1; word0 = 32'h03020100;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      e_inv  = (c <= 4) ? 8'(c - 1) : 8'h00;
      e_word = (c >= 5) ? 32'hF68D0100 : last_res0;
      checks++; if (busy0 !== (c <= 5)) begin errors++; $display("FAIL lat0_busy c%0d got %0b", c, busy0); end
      checks++; if (done0 !== (c == 5)) begin errors++; $display("FAIL lat0_done c%0d got %0b", c, done0); end
      checks++; if (invo0 !== e_inv) begin errors++; $display("FAIL lat0_inv c%0d got %h exp %h", c, invo0, e_inv); end
      checks++; if (wordo0 !== e_word) begin errors++; $display("FAIL lat0_word c%0d got %h exp %h", c, wordo0, e_word); end
      if (c == 1) begin start0 = 1'b0; word0 = $urandom; end
    end
    last_res0 = 32'hF68D0100;
  endtask

  task automatic test_lat2_directed();
    logic [7:0]  e_inv;
    logic [31:0] e_word;
    @(negedge clk);
    start2 = 1'b1; word2 = 32'h53535353;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      e_inv  = (c <= 12) ? 8'h53 : 8'h00;
      e_word = (c >= 13) ? 32'hCACACACA : last_res2;
      checks++; if (busy2 !== (c <= 13)) begin errors++; $display("FAIL lat2_busy c%0d got %0b", c, busy2); end
      checks++; if (done2 !== (c == 13)) begin errors++; $display("FAIL lat2_done c%0d got %0b", c, done2); end
      checks++; if (invo2 !== e_inv) begin errors++; $display("FAIL lat2_inv c%0d got %h exp %h", c, invo2, e_inv); end
      checks++; if (wordo2 !== e_word) begin errors++; $display("FAIL lat2_word c%0d got %h exp %h", c, wordo2, e_word); end
      if (c == 1) begin start2 = 1'b0; word2 = $urandom; end
    end
    last_res2 = 32'hCACACACA;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    exp_q.delete();
    for (int c = 0; c <= 35; c++) begin
      @(negedge clk);
      if (c > 0) begin
        checks++; if (done0 !== (c % 6 == 5)) begin errors++; $display("FAIL b2b_done c%0d got %0b", c, done0); end
        checks++; if (busy0 !== (c % 6 != 0)) begin errors++; $display("FAIL b2b_busy c%0d got %0b", c, busy0); end
        if (c % 6 == 5) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
          checks++; if (wordo0 !== e) begin errors++; $display("FAIL b2b_word c%0d got %h exp %h", c, wordo0, e); end
          last_res0 = e;
        end
      end
      start0 = 1'b1;
      word0  = $urandom;
      if (c % 6 == 0) exp_q.push_back(inv_word(word0));
    end
    start0 = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_clear();
    @(negedge clk);
    start0 = 1'b1; word0 = 32'h03020100;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    clear0 = 1'b1;
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL clr_busy got %0b exp 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL clr_done got %0b exp 0", done0); end
    checks++; if (invo0 !== 8'h00) begin errors++; $display("FAIL clr_inv got %h exp 00", invo0); end
    checks++; if (wordo0 !== last_res0) begin errors++; $display("FAIL clr_word got %h exp %h", wordo0, last_res0); end
    clear0 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (done0 !== 1'b0 || wordo0 !== last_res0) begin
        errors++; $display("FAIL clr_after c%0d done %0b word %h exp %h", c, done0, wordo0, last_res0);
      end
    end
    start0 = 1'b1; clear0 = 1'b1; word0 = $urandom;
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL clr_prio_busy got %0b exp 0", busy0); end
    start0 = 1'b0; clear0 = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    @(negedge clk);
    start0 = 1'b1; word0 = $urandom;
    @(negedge clk);
    start0 = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL arst_busy got %0b exp 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL arst_done got %0b exp 0", done0); end
    checks++; if (wordo0 !== 32'h0) begin errors++; $display("FAIL arst_word got %h exp 0", wordo0); end
    checks++; if (invo0 !== 8'h00) begin errors++; $display("FAIL arst_inv got %h exp 00", invo0); end
    last_res0 = '0;
    last_res2 = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    w = $urandom;
    start0 = 1'b1; word0 = w;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin start0 = 1'b0; word0 = $urandom; end
      checks++; if (done0 !== (c == 5)) begin errors++; $display("FAIL arst_restart_done c%0d got %0b", c, done0); end
      if (c == 5) begin
        checks++; if (wordo0 !== inv_word(w)) begin errors++; $display("FAIL arst_restart_word got %h exp %h", wordo0, inv_word(w)); end
      end
    end
    last_res0 = inv_word(w);
  endtask

  task automatic test_exhaustive();
    logic [7:0]  r [4];
    logic [31:0] w;
    int          lat;
    for (int k = 0; k < 4; k++) r[k] = 8'($urandom);
    for (int j = 0; j < 256; j++) begin
      w = {8'(j) ^ r[3], 8'(j) ^ r[2], 8'(j) ^ r[1], 8'(j) ^ r[0]};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      start0 = 1'b1; word0 = w;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (c == 1) begin start0 = 1'b0; word0 = $urandom; end
        if (done0 === 1'b1) begin lat = c; break; end
      end
      checks++; if (lat != 5 || wordo0 !== inv_word(w)) begin
        errors++; $display("FAIL exh_word j%0d lat %0d exp 5 got %h exp %h", j, lat, wordo0, inv_word(w));
      end
      last_res0 = inv_word(w);
    end
  endtask

  task automatic test_random_lat2();
    logic [31:0] w;
    int          lat;
    for (int j = 0; j < 12; j++) begin
      w = $urandom;
      @(negedge clk);
      start2 = 1'b1; word2 = w;
      lat = 0;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (c == 1) begin start2 = 1'b0; word2 = $urandom; end
        if (done2 === 1'b1) begin lat = c; break; end
      end
      checks++; if (lat != 13 || wordo2 !== inv_word(w)) begin
        errors++; $display("FAIL rnd2_word j%0d lat %0d exp 13 got %h exp %h", j, lat, wordo2, inv_word(w));
      end
      last_res2 = inv_word(w);
    end
  endtask

  initial begin
    build_table();
    test_reset();
    test_lat0_directed();
    test_lat2_directed();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_exhaustive();
    test_random_lat2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
